// File: rtl/alu_pkg.sv
// Shared definitions for the LEGv8 ALU family.
// Holds the sequencer state encoding, the NZCV bit positions and the datapath
// width default shared with the full-width 64-bit ALU.
package alu_pkg;

    localparam int ALU_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

    // Bit positions of the flags inside a packed {N,Z,C,V} nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/Four_Bit_Adder.sv
// 4-bit ripple-carry adder slice.
// Ports:
//   sum   out 4  a + b + c_in (low four bits)
//   c_out out 1  carry out of bit 3
//   a, b  in  4  addends
//   c_in  in  1  carry into bit 0
module Four_Bit_Adder (
    output logic [3:0] sum,
    output logic       c_out,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = c_in;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        c_out = c[4];
    end

endmodule

// File: rtl/nibble_serial_alu_adder.sv
// Nibble-serial add/subtract unit: computes a+b or a-b over WIDTH bits by
// pushing one nibble per clock through a single 4-bit ripple slice,
// least significant nibble first, then reports LEGv8 NZCV flags.
// Ports:
//   clk     in  1      rising-edge clock
//   rst_n   in  1      synchronous active-low reset
//   start   in  1      request, sampled in IDLE or DONE
//   sub     in  1      0: a+b, 1: a-b
//   a, b    in  WIDTH  operands, captured when start is accepted
//   busy    out 1      high while nibbles are being processed
//   done    out 1      one-cycle pulse, result/flags valid
//   result  out WIDTH  sum/difference, held until the next accepted start
//   flag_n/z/c/v out 1 NZCV of the last result
module nibble_serial_alu_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    alu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic             c_into_msb;

    Four_Bit_Adder u_slice (
        .sum   (slice_sum),
        .c_out (slice_cout),
        .a     (a_q[3:0]),
        .b     (b_q[3:0]),
        .c_in  (carry_q)
    );

    // On the final nibble, slice bit 3 is the result MSB; recover the carry
    // that entered it from the sum identity s = a ^ b ^ cin.
    assign c_into_msb = a_q[3] ^ b_q[3] ^ slice_sum[3];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        result_d = result_q;
        flags_d  = flags_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B here, the +1
                    // enters as the initial carry.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Sum nibbles enter at the top so that after NIBBLES shifts
                // the first nibble has reached bits [3:0].
                result_d = {slice_sum, result_q[WIDTH-1:4]};
                carry_d  = slice_cout;
                a_d      = a_q >> 4;
                b_d      = b_q >> 4;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d         = ST_DONE;
                    flags_d[FLAG_N] = slice_sum[3];
                    flags_d[FLAG_Z] = (result_d == '0);
                    flags_d[FLAG_C] = slice_cout;
                    flags_d[FLAG_V] = c_into_msb ^ slice_cout;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign flag_n = flags_q[FLAG_N];
    assign flag_z = flags_q[FLAG_Z];
    assign flag_c = flags_q[FLAG_C];
    assign flag_v = flags_q[FLAG_V];

endmodule

// File: tb/tb_nibble_serial_alu_adder.sv
// Bench for nibble_serial_alu_adder (WIDTH=64): directed operations issue
// expectations into a queue; a negedge monitor pops one entry per done pulse.
module tb_nibble_serial_alu_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        flag_n, flag_z, flag_c, flag_v;

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  nzcv;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   busy_cnt = 0;

    always #5 clk = ~clk;

    nibble_serial_alu_adder #(.WIDTH(64)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag_n (flag_n),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .flag_v (flag_v)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: one expectation per done pulse; also checks that busy lasted
    // exactly 16 cycles before the pulse and that busy is low during done.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            check("done_busy_exclusive", {63'd0, busy}, 64'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("nzcv", {60'd0, flag_n, flag_z, flag_c, flag_v}, {60'd0, e.nzcv});
                check("busy_cycles", 64'(busy_cnt), 64'd16);
            end
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end else begin
            busy_cnt = 0;
        end
    end

    // Raises start for one edge; returns on the first negedge after the
    // accepting edge. sync=0 drives in the current negedge (back-to-back).
    task automatic issue(input bit sync, input logic [63:0] ia, input logic [63:0] ib,
                         input logic isub, input bit push,
                         input logic [63:0] eres, input logic [3:0] enzcv);
        if (sync) @(negedge clk);
        a     = ia;
        b     = ib;
        sub   = isub;
        start = 1'b1;
        if (push) sb.push_back('{eres, enzcv});
        @(negedge clk);
        start = 1'b0;
    endtask

    // n0 = negedges already elapsed since start was driven.
    task automatic wait_done(input string name, input int n0);
        int n = n0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'd17);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_nzcv", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'd0);
        rst_n = 1'b1;

        // 1 + 1
        issue(1, 64'd1, 64'd1, 1'b0, 1, 64'd2, 4'b0000);
        check("run_busy_high", {63'd0, busy}, 64'd1);
        wait_done("add_1_1", 1);
        @(negedge clk);
        check("done_single_cycle", {63'd0, done}, 64'd0);
        check("result_held", result, 64'd2);

        // all-ones + 1 wraps to zero with carry
        issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1, 64'd0, 4'b0110);
        wait_done("add_wrap", 1);

        // largest positive + 1 overflows to most negative
        issue(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1, 64'h8000_0000_0000_0000, 4'b1001);
        wait_done("add_ovf", 1);

        // 5 - 5, then 3 - 5 issued straight from DONE
        issue(1, 64'd5, 64'd5, 1'b1, 1, 64'd0, 4'b0110);
        wait_done("sub_eq", 1);
        issue(0, 64'd3, 64'd5, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
        check("b2b_no_gap", {63'd0, busy}, 64'd1);
        wait_done("sub_neg", 1);

        // start pulses and operand changes during RUN are ignored
        issue(1, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1,
              64'h1234_5678_9ABC_DF00, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'b1;
            sub   = 1'b1;
            a     = {$urandom, $urandom};
            b     = {$urandom, $urandom};
        end
        @(negedge clk);
        start = 1'b0;
        wait_done("run_ignore", 10);

        // reset in RUN cycle 7: abort, no done pulse
        issue(1, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_1234_5678, 1'b0, 0, 64'd0, 4'b0000);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_result", result, 64'd0);
        check("abort_nzcv", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // after abort: most negative - 1 overflows to positive, no borrow
        issue(1, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
        wait_done("sub_ovf", 1);

        // 0 - 0
        issue(1, 64'd0, 64'd0, 1'b1, 1, 64'd0, 4'b0110);
        wait_done("sub_zero", 1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
